// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the decode-stage hazard/stall controller.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } hz_slot_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         MD_CNT_W = 6;

  // $0 is hardwired, so a read of it can never depend on an older writer.
  function automatic logic srcMatch(hz_slot_t slot, logic useBit, logic [4:0] src);
    return slot.valid & useBit & (src != REG_ZERO) & (src == slot.rd);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage request bundle and pipeline-control response of the hazard unit.
interface hazard_stall_unit_if;

  logic       ID_Valid;
  logic [4:0] ID_RegRs;
  logic [4:0] ID_RegRt;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic       ID_RegWrite;
  logic [4:0] ID_RegRd;
  logic       ID_MemRead;
  logic       ID_IsBranch;
  logic       ID_MdStart;
  logic       ID_MdRead;
  logic       Flush;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IDEXBubble;
  logic       MdBusy;

  modport master (
    output ID_Valid, ID_RegRs, ID_RegRt, ID_UseRs, ID_UseRt, ID_RegWrite,
           ID_RegRd, ID_MemRead, ID_IsBranch, ID_MdStart, ID_MdRead, Flush,
    input  PCWrite, IFIDWrite, IDEXBubble, MdBusy
  );

  modport slave (
    input  ID_Valid, ID_RegRs, ID_RegRt, ID_UseRs, ID_UseRt, ID_RegWrite,
           ID_RegRd, ID_MemRead, ID_IsBranch, ID_MdStart, ID_MdRead, Flush,
    output PCWrite, IFIDWrite, IDEXBubble, MdBusy
  );

endinterface

// File: rtl/hazard_stall_unit_md_counter.sv
// Saturating down-counter modelling the HI/LO multiply/divide latency.
module hazard_md_counter
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_CYCLES);

  logic [MD_CNT_W-1:0] cntReg;
  logic [MD_CNT_W-1:0] cntNext;

  // A start is only honoured from idle, so a running operation is never restarted.
  always_comb begin
    cntNext = cntReg;
    if (start && (cntReg == '0)) begin
      cntNext = LOAD_VAL;
    end else if (cntReg != '0) begin
      cntNext = cntReg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cntReg <= '0;
    end else begin
      cntReg <= cntNext;
    end
  end

  assign busy = (cntReg != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector: load-use, ID-branch and (HAZARD_MULDIV_EN) muldiv stalls.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_stall_unit_if.slave hz
);

  hz_slot_t   exReg;
  hz_slot_t   exNext;
  hz_slot_t   memReg;

  logic [4:0] srcReg [2];
  logic       srcUse [2];
  logic [1:0] exHit;
  logic [1:0] memHit;

  logic       loadUseStall;
  logic       branchStall;
  logic       mdStall;
  logic       mdBusyRaw;
  logic       stall;
  logic       issue;

  assign srcReg[0] = hz.ID_RegRs;
  assign srcReg[1] = hz.ID_RegRt;
  assign srcUse[0] = hz.ID_UseRs;
  assign srcUse[1] = hz.ID_UseRt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSrc
      assign exHit[gi]  = srcMatch(exReg, srcUse[gi], srcReg[gi]);
      assign memHit[gi] = srcMatch(memReg, srcUse[gi], srcReg[gi]);
    end
  endgenerate

  // Branches compare in ID, so even an ALU result in EX is too late to forward.
  assign loadUseStall = (|exHit) & exReg.load;
  assign branchStall  = hz.ID_IsBranch & ((|exHit) | ((|memHit) & memReg.load));

`ifdef HAZARD_MULDIV_EN
  logic mdStartIssue;

  assign mdStall      = mdBusyRaw & (hz.ID_MdStart | hz.ID_MdRead);
  assign mdStartIssue = hz.ID_Valid & hz.ID_MdStart & ~stall & ~hz.Flush;

  hazard_md_counter #(
    .MD_CYCLES (MD_CYCLES)
  ) uMdCounter (
    .clk   (clk),
    .rst   (rst),
    .start (mdStartIssue),
    .busy  (mdBusyRaw)
  );
`else
  logic unusedMd;

  assign mdStall   = 1'b0;
  assign mdBusyRaw = 1'b0;
  assign unusedMd  = hz.ID_MdStart ^ hz.ID_MdRead ^ (MD_CYCLES != 0);
`endif

  assign stall = hz.ID_Valid & ~hz.Flush & (loadUseStall | branchStall | mdStall);
  assign issue = hz.ID_Valid & hz.ID_RegWrite & (hz.ID_RegRd != REG_ZERO) & ~stall & ~hz.Flush;

  always_comb begin
    exNext       = '0;
    exNext.valid = issue;
    exNext.rd    = hz.ID_RegRd;
    exNext.load  = hz.ID_MemRead;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exReg  <= '0;
      memReg <= '0;
    end else begin
      memReg <= exReg;
      exReg  <= exNext;
    end
  end

  // Flush wins over every stall; reset wins over everything.
  always_comb begin
    hz.PCWrite    = 1'b1;
    hz.IFIDWrite  = 1'b1;
    hz.IDEXBubble = 1'b0;
    hz.MdBusy     = 1'b0;
    if (!rst) begin
      hz.MdBusy = mdBusyRaw;
      if (hz.Flush) begin
        hz.IDEXBubble = 1'b1;
      end else if (stall) begin
        hz.PCWrite    = 1'b0;
        hz.IFIDWrite  = 1'b0;
        hz.IDEXBubble = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed hazards, then random traffic vs a history model.
module tb_hazard_stall_unit;

  localparam int MD_CYCLES = 32;

  typedef struct {
    bit       valid;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       useRs;
    bit       useRt;
    bit       regWrite;
    bit [4:0] rd;
    bit       memRead;
    bit       isBranch;
    bit       mdStart;
    bit       mdRead;
    bit       flush;
    bit       rst;
  } instr_t;

  typedef struct {
    int       cycle;
    bit [4:0] rd;
    bit       load;
  } writer_t;

  // Expected {PCWrite, IFIDWrite, IDEXBubble, MdBusy}
  localparam logic [3:0] EXP_RUN   = 4'b1100;
  localparam logic [3:0] EXP_STALL = 4'b0010;
  localparam logic [3:0] EXP_FLUSH = 4'b1110;
`ifdef HAZARD_MULDIV_EN
  localparam logic [3:0] EXP_MDSTALL = 4'b0011;
  localparam logic [3:0] EXP_MDRUN   = 4'b1101;
`else
  localparam logic [3:0] EXP_MDSTALL = 4'b1100;
  localparam logic [3:0] EXP_MDRUN   = 4'b1100;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_unit_if hzIf ();

  hazard_stall_unit #(
    .MD_CYCLES (MD_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hzIf.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] expQ[$];
  string      tagQ[$];
  int         cycQ[$];

  // Reference model state: history of issued GPR writers and the last busy cycle of the muldiv unit.
  writer_t    writers[$];
  int         cyc        = 0;
  int         mdLastBusy = -1;

  function automatic bit readsReg(instr_t in, bit [4:0] r);
    return (r != 5'd0) && ((in.useRs && in.rs == r) || (in.useRt && in.rt == r));
  endfunction

  task automatic model(input instr_t in, output logic [3:0] e);
    bit stall  = 1'b0;
    bit mdBusy = 1'b0;
    bit issue;
    writer_t keep[$];
    if (in.rst) begin
      writers.delete();
      mdLastBusy = -1;
      e = 4'b1100;
    end else begin
`ifdef HAZARD_MULDIV_EN
      mdBusy = (cyc <= mdLastBusy);
`endif
      if (in.valid && !in.flush) begin
        foreach (writers[i]) begin
          int age = cyc - writers[i].cycle;
          if (readsReg(in, writers[i].rd)) begin
            if (age == 1 && (writers[i].load || in.isBranch)) stall = 1'b1;
            if (age == 2 && writers[i].load && in.isBranch) stall = 1'b1;
          end
        end
        if (mdBusy && (in.mdStart || in.mdRead)) stall = 1'b1;
      end
      issue = in.valid && !in.flush && !stall;
`ifdef HAZARD_MULDIV_EN
      if (issue && in.mdStart) mdLastBusy = cyc + MD_CYCLES;
`endif
      if (issue && in.regWrite && in.rd != 5'd0) writers.push_back('{cyc, in.rd, in.memRead});
      if (in.flush)      e = {3'b111, mdBusy};
      else if (stall)    e = {3'b001, mdBusy};
      else               e = {3'b110, mdBusy};
    end
    foreach (writers[i]) if (cyc - writers[i].cycle < 2) keep.push_back(writers[i]);
    writers = keep;
    cyc++;
  endtask

  task automatic drive(input instr_t in);
    rst              = in.rst;
    hzIf.ID_Valid    = in.valid;
    hzIf.ID_RegRs    = in.rs;
    hzIf.ID_RegRt    = in.rt;
    hzIf.ID_UseRs    = in.useRs;
    hzIf.ID_UseRt    = in.useRt;
    hzIf.ID_RegWrite = in.regWrite;
    hzIf.ID_RegRd    = in.rd;
    hzIf.ID_MemRead  = in.memRead;
    hzIf.ID_IsBranch = in.isBranch;
    hzIf.ID_MdStart  = in.mdStart;
    hzIf.ID_MdRead   = in.mdRead;
    hzIf.Flush       = in.flush;
  endtask

  // useDir=1 pushes a hand-derived expectation; the model still advances to stay in step.
  task automatic step(input instr_t in, input bit useDir, input logic [3:0] dirExp, input string tag);
    logic [3:0] m;
    @(posedge clk);
    #1;
    drive(in);
    cycQ.push_back(cyc);
    model(in, m);
    expQ.push_back(useDir ? dirExp : m);
    tagQ.push_back(tag);
  endtask

  function automatic instr_t nopI();
    instr_t n;
    n = '{default: '0};
    return n;
  endfunction

  function automatic instr_t rstI();
    instr_t n = nopI();
    n.rst = 1'b1;
    return n;
  endfunction

  function automatic instr_t aluI(bit [4:0] rd, bit [4:0] rs, bit [4:0] rt);
    instr_t n = nopI();
    n.valid = 1'b1; n.regWrite = 1'b1; n.rd = rd;
    n.rs = rs; n.rt = rt; n.useRs = 1'b1; n.useRt = 1'b1;
    return n;
  endfunction

  function automatic instr_t lwI(bit [4:0] rd, bit [4:0] rs);
    instr_t n = nopI();
    n.valid = 1'b1; n.regWrite = 1'b1; n.rd = rd; n.memRead = 1'b1;
    n.rs = rs; n.useRs = 1'b1;
    return n;
  endfunction

  function automatic instr_t beqI(bit [4:0] rs, bit [4:0] rt);
    instr_t n = nopI();
    n.valid = 1'b1; n.isBranch = 1'b1;
    n.rs = rs; n.rt = rt; n.useRs = 1'b1; n.useRt = 1'b1;
    return n;
  endfunction

  function automatic instr_t divI();
    instr_t n = nopI();
    n.valid = 1'b1; n.mdStart = 1'b1; n.rs = 5'd1; n.rt = 5'd1;
    return n;
  endfunction

  function automatic instr_t mfloI(bit [4:0] rd);
    instr_t n = nopI();
    n.valid = 1'b1; n.mdRead = 1'b1; n.regWrite = 1'b1; n.rd = rd;
    return n;
  endfunction

  function automatic instr_t randI();
    instr_t n = nopI();
    n.valid    = ($urandom_range(0, 9) != 0);
    n.rs       = 5'($urandom_range(0, 7));
    n.rt       = 5'($urandom_range(0, 7));
    n.useRs    = $urandom_range(0, 3) != 0;
    n.useRt    = $urandom_range(0, 1) != 0;
    n.regWrite = $urandom_range(0, 2) != 0;
    n.rd       = 5'($urandom_range(0, 7));
    n.memRead  = n.regWrite && ($urandom_range(0, 2) == 0);
    n.isBranch = !n.regWrite && ($urandom_range(0, 1) == 0);
    n.mdStart  = !n.regWrite && ($urandom_range(0, 19) == 0);
    n.mdRead   = n.regWrite && ($urandom_range(0, 9) == 0);
    n.flush    = ($urandom_range(0, 11) == 0);
    n.rst      = ($urandom_range(0, 99) == 0);
    return n;
  endfunction

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [3:0] e;
      logic [3:0] got;
      string      t;
      int         c;
      e   = expQ.pop_front();
      t   = tagQ.pop_front();
      c   = cycQ.pop_front();
      got = {hzIf.PCWrite, hzIf.IFIDWrite, hzIf.IDEXBubble, hzIf.MdBusy};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got {PCWrite,IFIDWrite,IDEXBubble,MdBusy}=%b expected %b", t, c, got, e);
      end else begin
        $display("ok   %s cyc=%0d outputs=%b", t, c, got);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t in;
    drive(rstI());

    step(rstI(), 1'b1, EXP_RUN, "reset");
    step(rstI(), 1'b1, EXP_RUN, "reset");

    step(lwI(5'd2, 5'd0),         1'b1, EXP_RUN,   "lu_lw");
    step(aluI(5'd6, 5'd2, 5'd0),  1'b1, EXP_STALL, "lu_stall");
    step(aluI(5'd6, 5'd2, 5'd0),  1'b1, EXP_RUN,   "lu_issue");

    step(aluI(5'd3, 5'd1, 5'd1),  1'b1, EXP_RUN,   "br_alu_add");
    step(beqI(5'd0, 5'd3),        1'b1, EXP_STALL, "br_alu_stall");
    step(beqI(5'd0, 5'd3),        1'b1, EXP_RUN,   "br_alu_issue");

    step(lwI(5'd4, 5'd0),         1'b1, EXP_RUN,   "br_lw_lw");
    step(beqI(5'd4, 5'd0),        1'b1, EXP_STALL, "br_lw_stall1");
    step(beqI(5'd4, 5'd0),        1'b1, EXP_STALL, "br_lw_stall2");
    step(beqI(5'd4, 5'd0),        1'b1, EXP_RUN,   "br_lw_issue");

    step(lwI(5'd0, 5'd0),         1'b1, EXP_RUN,   "r0_lw");
    step(aluI(5'd8, 5'd0, 5'd0),  1'b1, EXP_RUN,   "r0_use");
    step(lwI(5'd5, 5'd0),         1'b1, EXP_RUN,   "unused_lw");
    in = aluI(5'd9, 5'd1, 5'd5);
    in.useRt = 1'b0;
    step(in,                      1'b1, EXP_RUN,   "unused_rt");

    step(lwI(5'd7, 5'd0),         1'b1, EXP_RUN,   "fl_lw");
    in = aluI(5'd10, 5'd7, 5'd0);
    in.flush = 1'b1;
    step(in,                      1'b1, EXP_FLUSH, "fl_flush");
    step(aluI(5'd11, 5'd7, 5'd0), 1'b1, EXP_RUN,   "fl_ex_invalid");

    step(divI(),                  1'b1, EXP_RUN,   "md_div");
    for (int i = 1; i <= MD_CYCLES; i++) step(mfloI(5'd12), 1'b1, EXP_MDSTALL, "md_wait");
    step(mfloI(5'd12),            1'b1, EXP_RUN,   "md_issue");

    step(divI(),                  1'b1, EXP_RUN,   "mdr_div");
    for (int i = 1; i <= 3; i++) step(nopI(), 1'b1, EXP_MDRUN, "mdr_busy");
    step(lwI(5'd13, 5'd0),        1'b1, EXP_MDRUN, "mdr_lw");
    step(rstI(),                  1'b1, EXP_RUN,   "mdr_reset");
    step(beqI(5'd13, 5'd0),       1'b1, EXP_RUN,   "mdr_slots_clear");
    step(mfloI(5'd14),            1'b1, EXP_RUN,   "mdr_md_clear");

    for (int i = 0; i < 600; i++) step(randI(), 1'b0, 4'b0000, "rand");

    step(nopI(), 1'b0, 4'b0000, "drain");
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
